// File: rtl/divi_ctrl.sv
// Divider-core front end: registers operands into a pipelined divider, tracks
// in-flight results with a tag pipeline and buffers them in a small credit-managed FIFO.
module divi_ctrl #(
    parameter int DIV_LATENCY = 28,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_dividend,
    input  logic [15:0] in_divisor,
    output logic [24:0] div_dividend,
    output logic [15:0] div_divisor,
    output logic        div_ce,
    input  logic        div_rfd,
    input  logic [24:0] div_quotient,
    input  logic [15:0] div_fractional,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_quotient,
    output logic [15:0] out_fractional,
    output logic        out_div0
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 25 + 16 + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic          accept;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          exit_div0;
    logic [CW:0]   credit_used;
    logic [24:0]   dividend_q;
    logic [15:0]   divisor_q;
    logic [1:0]    issue_tag_q;
    logic [1:0]    tag_q [DIV_LATENCY];
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;

    // Every accepted operand reserves a FIFO slot until its result is popped.
    assign credit_used = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    assign in_ready    = !sys_rst && div_rfd && (credit_used < DEPTH_C);
    assign accept      = in_valid && in_ready;
    assign div_ce      = !sys_rst;

    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
        end else if (accept) begin
            dividend_q <= in_dividend;
            divisor_q  <= in_divisor;
        end
    end

    // issue_tag_q sits alongside the operand registers; tag_q then mirrors the core latency.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            issue_tag_q <= '0;
            for (int i = 0; i < DIV_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            issue_tag_q <= {accept, accept && (in_divisor == 16'd0)};
            tag_q[0]    <= issue_tag_q;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign fifo_wr   = !sys_rst && tag_q[DIV_LATENCY-1][1];
    assign exit_div0 = tag_q[DIV_LATENCY-1][0];
    assign wr_entry  = exit_div0 ? {25'h1FFFFFF, 16'h0000, 1'b1}
                                 : {div_quotient, div_fractional, 1'b0};

    always_ff @(posedge sys_clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign out_valid  = !sys_rst && (fifo_count_q != '0);
    assign fifo_rd    = out_valid && out_ready;

    always_comb begin
        out_quotient   = '0;
        out_fractional = '0;
        out_div0       = 1'b0;
        if (out_valid) begin
            out_quotient   = head_entry[EW-1 -: 25];
            out_fractional = head_entry[16:1];
            out_div0       = head_entry[0];
        end
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, fifo_wr})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Pointers are exactly PW bits wide, so they wrap modulo FIFO_DEPTH on their own.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fifo_count_q <= '0;
            inflight_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
        !(fifo_wr && (fifo_count_q == CW'(FIFO_DEPTH))));

endmodule
